// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 4-way round-robin mux-select arbiter.
package mux_arb_pkg;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

endpackage

// File: rtl/rr_pick4.sv
// Rotate-priority encoder: first set request bit searching ptr+1, ptr+2, ptr+3, ptr.
import mux_arb_pkg::*;

module rr_pick4 (
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] win
);

    logic [SEL_W-1:0] idx;

    // Walk the rotated order once; the first hit after the last owner wins.
    always_comb begin
        any = 1'b0;
        win = '0;
        idx = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = ptr + SEL_W'(k);
            if (!any && req[idx]) begin
                any = 1'b1;
                win = idx;
            end
        end
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter owning a 4:1 mux select; holds the grant until done
// or until a programmable BUSY-cycle timeout aborts the transaction.
import mux_arb_pkg::*;

module mux_sel_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic             done,
    output logic [NREQ-1:0]  gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             start,
    output logic             timeout_err
);

    // Counter width derived from TIMEOUT; a disabled timeout still keeps a 1-bit counter.
    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    arb_state_t       state;
    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic             pick_any;
    logic [SEL_W-1:0] pick_win;
    logic             timeout_hit;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .win (pick_win)
    );

    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

    // Arbitration FSM with all outputs registered; sel doubles as the owner index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ARB_IDLE;
            gnt         <= '0;
            sel         <= '0;
            busy        <= 1'b0;
            start       <= 1'b0;
            timeout_err <= 1'b0;
            ptr         <= SEL_W'(NREQ - 1);
            cnt         <= '0;
        end else begin
            start       <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        state <= ARB_BUSY;
                        gnt   <= NREQ'(1) << pick_win;
                        sel   <= pick_win;
                        busy  <= 1'b1;
                        start <= 1'b1;
                        cnt   <= '0;
                    end
                end
                ARB_BUSY: begin
                    if (done || timeout_hit) begin
                        state       <= ARB_IDLE;
                        gnt         <= '0;
                        busy        <= 1'b0;
                        ptr         <= sel;
                        timeout_err <= !done;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed-vector scoreboard bench for mux_sel_arbiter (TIMEOUT=4).
module tb_mux_sel_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = '0;
    logic       done = 1'b0;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       start;
    logic       timeout_err;

    always #5 clk = ~clk;

    mux_sel_arbiter #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .gnt         (gnt),
        .sel         (sel),
        .busy        (busy),
        .start       (start),
        .timeout_err (timeout_err)
    );

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       start;
        logic       terr;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Apply one input vector for the next posedge and queue the outputs expected after it.
    task automatic vec(input logic r, input logic [3:0] rq, input logic d,
                       input logic [3:0] g, input logic [1:0] s, input logic b,
                       input logic st, input logic te, input string nm);
        obs_t e;
        @(negedge clk);
        #1;
        reset = r;
        req   = rq;
        done  = d;
        e.gnt = g; e.sel = s; e.busy = b; e.start = st; e.terr = te;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: one queued expectation is due at each falling edge.
    initial begin
        obs_t  e;
        obs_t  a;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a.gnt = gnt; a.sel = sel; a.busy = busy; a.start = start; a.terr = timeout_err;
                n_checks++;
                if (a === e) n_pass++;
                else $display("FAIL %s: got gnt=%b sel=%0d busy=%b start=%b terr=%b, expected gnt=%b sel=%0d busy=%b start=%b terr=%b",
                              nm, a.gnt, a.sel, a.busy, a.start, a.terr,
                              e.gnt, e.sel, e.busy, e.start, e.terr);
            end
        end
    end

    initial begin
        int owners[5] = '{0, 1, 2, 3, 0};
        logic [3:0] g;
        repeat (2) @(negedge clk);

        // 1: reset then first grant to requester 0, next to requester 2
        vec(1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, "t1_reset");
        vec(0, 4'b0101, 0, 4'b0001, 0, 1, 1, 0, "t1_grant0");
        vec(0, 4'b0101, 0, 4'b0001, 0, 1, 0, 0, "t1_hold0");
        vec(0, 4'b0101, 1, 4'b0000, 0, 0, 0, 0, "t1_release0");
        vec(0, 4'b0101, 0, 4'b0100, 2, 1, 1, 0, "t1_grant2");
        vec(0, 4'b0000, 1, 4'b0000, 2, 0, 0, 0, "t1_release2");

        // 2: all requesting, rotation 0,1,2,3,0
        vec(1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, "t2_reset");
        for (int i = 0; i < 5; i++) begin
            g = 4'b0001 << owners[i];
            vec(0, 4'b1111, 0, g, 2'(owners[i]), 1, 1, 0, $sformatf("t2_grant%0d", i));
            vec(0, 4'b1111, 0, g, 2'(owners[i]), 1, 0, 0, $sformatf("t2_hold%0d", i));
            vec(0, 4'b1111, 1, 4'b0000, 2'(owners[i]), 0, 0, 0, $sformatf("t2_release%0d", i));
        end

        // 3: done on the start cycle, grant every other cycle
        for (int i = 0; i < 3; i++) begin
            vec(0, 4'b0010, 0, 4'b0010, 1, 1, 1, 0, $sformatf("t3_grant%0d", i));
            vec(0, 4'b0010, 1, 4'b0000, 1, 0, 0, 0, $sformatf("t3_idle%0d", i));
        end

        // 4: timeout after 4 busy cycles, then requester 1 wins
        vec(0, 4'b0001, 0, 4'b0001, 0, 1, 1, 0, "t4_grant0");
        vec(0, 4'b0001, 0, 4'b0001, 0, 1, 0, 0, "t4_busy2");
        vec(0, 4'b0001, 0, 4'b0001, 0, 1, 0, 0, "t4_busy3");
        vec(0, 4'b0001, 0, 4'b0001, 0, 1, 0, 0, "t4_busy4");
        vec(0, 4'b0011, 0, 4'b0000, 0, 0, 0, 1, "t4_abort");
        vec(0, 4'b0011, 0, 4'b0010, 1, 1, 1, 0, "t4_grant1");
        vec(0, 4'b0000, 1, 4'b0000, 1, 0, 0, 0, "t4_release1");

        // 5: reset while requester 2 owns the resource
        vec(0, 4'b0100, 0, 4'b0100, 2, 1, 1, 0, "t5_grant2");
        vec(1, 4'b0100, 0, 4'b0000, 0, 0, 0, 0, "t5_reset_busy");
        vec(0, 4'b1001, 0, 4'b0001, 0, 1, 1, 0, "t5_grant0");
        vec(0, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, "t5_release0");

        // 6: owner drops req, done collides with timeout, done pulses in IDLE
        vec(0, 4'b0100, 0, 4'b0100, 2, 1, 1, 0, "t6_grant2");
        vec(0, 4'b0000, 0, 4'b0100, 2, 1, 0, 0, "t6_drop_hold1");
        vec(0, 4'b0000, 0, 4'b0100, 2, 1, 0, 0, "t6_drop_hold2");
        vec(0, 4'b0000, 0, 4'b0100, 2, 1, 0, 0, "t6_drop_hold3");
        vec(0, 4'b0000, 1, 4'b0000, 2, 0, 0, 0, "t6_done_beats_timeout");
        vec(0, 4'b0000, 1, 4'b0000, 2, 0, 0, 0, "t6_done_in_idle");
        vec(0, 4'b0000, 0, 4'b0000, 2, 0, 0, 0, "t6_idle_quiet");
        vec(0, 4'b1000, 0, 4'b1000, 3, 1, 1, 0, "t6_grant3");

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
